// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch flush,
// multi-cycle MDU occupancy FSM and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
    parameter int ADDR_W  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic              LoadE,
    input  logic              MduStartE,
    input  logic              PCSrcE,
    input  logic              MemStallM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MduBusy,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam int MCW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [MCW-1:0] MDU_INIT = MCW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [MCW-1:0]   r_mdu_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_mdu_start;
    logic w_stall_f;

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
            ForwardAE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
            ForwardBE = 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
            ForwardBE = 2'b01;
    end

    assign w_load_use  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_mdu_start = MduStartE && (MDU_LAT > 1);

    // Priority: memory stall > MDU occupancy > branch > MDU start > load-use.
    always_comb begin
        w_stall_f = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (MemStallM) begin
            w_stall_f = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            StallM    = 1'b1;
        end else if (r_state == BUSY) begin
            if (r_mdu_cnt != '0) begin
                w_stall_f = 1'b1;
                StallD    = 1'b1;
                StallE    = 1'b1;
                FlushM    = 1'b1;
            end
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_mdu_start) begin
            w_stall_f = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            FlushM    = 1'b1;
        end else if (w_load_use) begin
            w_stall_f = 1'b1;
            StallD    = 1'b1;
            FlushE    = 1'b1;
        end
    end

    assign StallF   = w_stall_f;
    assign MduBusy  = (r_state == BUSY);
    assign StallCnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_mdu_cnt <= '0;
        end else if (!MemStallM) begin
            case (r_state)
                RUN: begin
                    if (!PCSrcE && w_mdu_start) begin
                        r_state   <= BUSY;
                        r_mdu_cnt <= MDU_INIT;
                    end
                end
                BUSY: begin
                    if (r_mdu_cnt != '0)
                        r_mdu_cnt <= r_mdu_cnt - MCW'(1);
                    else
                        r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall_f && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

endmodule
